// File: rtl/seg_scan_display.sv
// ============================================================================
// Module   : seg_scan_display
// Brief    : Time-multiplexed 7-segment driver for NUM_DIGITS common-anode
//            digits. It uses a refresh prescaler, inserts dead time between
//            slots, takes a frame-coherent snapshot of the inputs and shows
//            a dash for invalid codes.
//            Optional macro SEG_LZ_BLANK_EN enables leading-zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 100000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [4*NUM_DIGITS-1:0]   bcd,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] c_cnt_max = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] c_idx_max = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    c_seg_off = 7'h7F;

    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_snap_bcd;
    logic [NUM_DIGITS-1:0]   r_snap_dp;

    logic                    w_take;
    logic [4*NUM_DIGITS-1:0] w_src_bcd;
    logic [NUM_DIGITS-1:0]   w_src_dp;
    logic [3:0]              w_dig [NUM_DIGITS];
    logic [3:0]              w_nib;
    logic [6:0]              w_seg_dec;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_an;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] res;
        case (nib)
            4'd0:    res = 7'b1000000;
            4'd1:    res = 7'b1111001;
            4'd2:    res = 7'b0100100;
            4'd3:    res = 7'b0110000;
            4'd4:    res = 7'b0011001;
            4'd5:    res = 7'b0010010;
            4'd6:    res = 7'b0000010;
            4'd7:    res = 7'b1111000;
            4'd8:    res = 7'b0000000;
            4'd9:    res = 7'b0011000;
            default: res = 7'b0111111;
        endcase
        return res;
    endfunction

    // The snapshot loads at slot (0,0); the output stage reads the live
    // inputs that cycle, so slot 0 already shows the new frame's data.
    assign w_take    = enable && (r_cnt == '0) && (r_idx == '0);
    assign w_src_bcd = w_take ? bcd   : r_snap_bcd;
    assign w_src_dp  = w_take ? dp_in : r_snap_dp;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
            assign w_dig[gi] = w_src_bcd[4*gi +: 4];
        end
    endgenerate

    assign w_nib     = w_dig[r_idx];
    assign w_seg_dec = f_decode(w_nib);

`ifdef SEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] w_sup;
    logic                  w_zero_above;

    // Walk down from the top digit; a digit is blank while everything from it up is zero.
    always_comb begin
        w_sup        = '0;
        w_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (w_dig[i] == 4'd0);
            w_sup[i]     = w_zero_above;
        end
    end

    assign w_seg = w_sup[r_idx] ? c_seg_off : w_seg_dec;
`else
    assign w_seg = w_seg_dec;
`endif

    always_comb begin
        w_an = '1;
        if (int'(r_cnt) >= BLANK_CYC) begin
            w_an[r_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_snap_bcd <= '0;
            r_snap_dp  <= '0;
        end else if (enable) begin
            if (w_take) begin
                r_snap_bcd <= bcd;
                r_snap_dp  <= dp_in;
            end
            if (r_cnt == c_cnt_max) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= '1;
            seg         <= c_seg_off;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else if (!enable) begin
            an          <= '1;
            seg         <= c_seg_off;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= w_an;
            seg         <= w_seg;
            dp          <= ~w_src_dp[r_idx];
            frame_start <= w_take;
        end
    end

endmodule

`default_nettype wire
